// File: rtl/axi4_lite_read_master_if.sv
// Bundle of the core-side request/response handshake and the AXI4-Lite read
// channels (AR and R) used by axi4_lite_read_master.
//   master modport : the read master's view (drives AR, R_READY, REQ_READY, RSP_*)
//   slave  modport : the surrounding world's view (core + AXI read slave)
interface axi4_lite_read_master_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    // Core request/response side
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [ADDR_W-1:0] REQ_ADDR;
    logic              RSP_VALID;
    logic              RSP_READY;
    logic [DATA_W-1:0] RSP_DATA;
    logic [1:0]        RSP_ERR;
    logic              TIMEOUT_FLAG;

    // AXI4-Lite read address and read data channels
    logic [ADDR_W-1:0] AR_ADDR;
    logic              AR_VALID;
    logic              AR_READY;
    logic [DATA_W-1:0] R_DATA;
    logic [1:0]        R_RESP;
    logic              R_VALID;
    logic              R_READY;

    modport master (
        input  REQ_VALID, REQ_ADDR, RSP_READY, AR_READY, R_DATA, R_RESP, R_VALID,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, TIMEOUT_FLAG, AR_ADDR, AR_VALID,
        output R_READY
    );

    modport slave (
        output REQ_VALID, REQ_ADDR, RSP_READY, AR_READY, R_DATA, R_RESP, R_VALID,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, TIMEOUT_FLAG, AR_ADDR, AR_VALID,
        input  R_READY
    );
endinterface

// File: rtl/axi4_lite_read_master.sv
// AXI4-Lite read master with a single outstanding transaction.
// A core request (REQ_VALID/REQ_ADDR) is turned into one AR beat, the matching
// R beat is captured, and RSP_DATA/RSP_ERR are offered back to the core until
// RSP_READY. A watchdog pulses TIMEOUT_FLAG once if the AXI side stalls for
// TIMEOUT cycles; the transaction keeps waiting so the protocol stays legal.
// Ports:
//   CLK  - clock, all state updates on the rising edge
//   RST  - synchronous active-high reset; abandons any in-flight read
//   bus  - master modport of axi4_lite_read_master_if (core + AR/R channels)
// All outputs come straight from flops or from a decode of the state register.
module axi4_lite_read_master #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                          CLK,
    input  logic                          RST,
    axi4_lite_read_master_if.master       bus
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    // Counter must be able to hold TIMEOUT itself (its saturated value).
    localparam int unsigned   CntW   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] WdLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] WdMax  = CntW'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic [CntW-1:0]   wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d;
    logic              in_wait;

    // Transaction FSM and capture registers
    always_comb begin
        state_d    = state_q;
        ar_addr_d  = ar_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            StIdle: begin
                if (bus.REQ_VALID) begin
                    ar_addr_d = bus.REQ_ADDR;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                // R_VALID is deliberately ignored here, even if it coincides
                // with AR_READY; the data beat is only taken in StData.
                if (bus.AR_READY) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (bus.R_VALID) begin
                    rsp_data_d = bus.R_DATA;
                    rsp_err_d  = bus.R_RESP;
                    state_d    = StResp;
                end
            end
            StResp: begin
                if (bus.RSP_READY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Watchdog: counts cycles spent waiting on the AXI slave, fires once at
    // TIMEOUT-1 and then saturates so the flag cannot repeat.
    always_comb begin
        in_wait   = (state_q == StAddr) || (state_q == StData);
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
        if (TIMEOUT != 0) begin
            if (state_d == StIdle) begin
                wd_cnt_d = '0;
            end else if (in_wait && (wd_cnt_q != WdMax)) begin
                wd_cnt_d = wd_cnt_q + CntW'(1);
            end
            timeout_d = in_wait && (wd_cnt_q == WdLast);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            ar_addr_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
            wd_cnt_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ar_addr_q  <= ar_addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            wd_cnt_q   <= wd_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.REQ_READY    = (state_q == StIdle);
    assign bus.AR_VALID     = (state_q == StAddr);
    assign bus.AR_ADDR      = ar_addr_q;
    assign bus.R_READY      = (state_q == StData);
    assign bus.RSP_VALID    = (state_q == StResp);
    assign bus.RSP_DATA     = rsp_data_q;
    assign bus.RSP_ERR      = rsp_err_q;
    assign bus.TIMEOUT_FLAG = timeout_q;

endmodule

// File: tb/tb_axi4_lite_read_master.sv
// Self-checking bench for axi4_lite_read_master: directed scenarios followed
// by randomized stimulus, all outputs compared every cycle against a
// transaction-level reference model.
module tb_axi4_lite_read_master;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned TIMEOUT = 8;

    logic CLK;
    logic RST;

    axi4_lite_read_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    axi4_lite_read_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one read in flight, described by what has happened to it.
    logic              m_ok;     // model is meaningful (a reset has been seen)
    logic              m_busy;   // a request has been accepted
    logic              m_sent;   // its address has been accepted by the slave
    logic              m_have;   // its data has arrived and waits for the core
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [1:0]        m_err;
    logic              m_flag;
    int                m_wait;   // cycles this read has spent waiting on AXI

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: check current outputs, drive inputs for the coming
    // edge, then advance the model by what that edge will do.
    task automatic step(input logic rst, input logic req_v, input logic [63:0] addr,
                        input logic ar_rdy, input logic r_v, input logic [63:0] rdata,
                        input logic [1:0] rresp, input logic rsp_rdy);
        logic in_wait;
        @(negedge CLK);
        if (m_ok) begin
            check_eq("req_ready", 64'(bus.REQ_READY), 64'(!m_busy));
            check_eq("ar_valid", 64'(bus.AR_VALID), 64'(m_busy && !m_sent));
            check_eq("ar_addr", bus.AR_ADDR, m_addr);
            check_eq("r_ready", 64'(bus.R_READY), 64'(m_busy && m_sent && !m_have));
            check_eq("rsp_valid", 64'(bus.RSP_VALID), 64'(m_have));
            check_eq("rsp_data", bus.RSP_DATA, m_data);
            check_eq("rsp_err", 64'(bus.RSP_ERR), 64'(m_err));
            check_eq("timeout_flag", 64'(bus.TIMEOUT_FLAG), 64'(m_flag));
        end
        RST           = rst;
        bus.REQ_VALID = req_v;
        bus.REQ_ADDR  = addr;
        bus.AR_READY  = ar_rdy;
        bus.R_VALID   = r_v;
        bus.R_DATA    = rdata;
        bus.R_RESP    = rresp;
        bus.RSP_READY = rsp_rdy;

        if (rst) begin
            m_ok = 1'b1; m_busy = 1'b0; m_sent = 1'b0; m_have = 1'b0;
            m_addr = '0; m_data = '0; m_err = '0; m_flag = 1'b0; m_wait = 0;
        end else begin
            in_wait = m_busy && !m_have;
            m_flag  = (TIMEOUT != 0) && in_wait && (m_wait + 1 == int'(TIMEOUT));
            if (in_wait) m_wait++;
            if (!m_busy) begin
                if (req_v) begin
                    m_busy = 1'b1; m_sent = 1'b0; m_addr = addr; m_wait = 0;
                end
            end else if (!m_sent) begin
                if (ar_rdy) m_sent = 1'b1;
            end else if (!m_have) begin
                if (r_v) begin
                    m_have = 1'b1; m_data = rdata; m_err = rresp;
                end
            end else if (rsp_rdy) begin
                m_busy = 1'b0; m_have = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b0);
    endtask

    // Full read with the given stall counts on each phase.
    task automatic run_read(input logic [63:0] addr, input int ar_stall, input int r_stall,
                            input int rsp_stall, input logic [63:0] rdata,
                            input logic [1:0] rresp);
        step(1'b0, 1'b1, addr, 1'b0, 1'b0, '0, 2'b00, 1'b0);
        for (int i = 0; i < ar_stall; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 2'b00, 1'b0);
        for (int i = 0; i < r_stall; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, rdata, rresp, 1'b0);
        for (int i = 0; i < rsp_stall; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b1);
    endtask

    initial begin
        m_ok = 1'b0; m_busy = 1'b0; m_sent = 1'b0; m_have = 1'b0;
        m_addr = '0; m_data = '0; m_err = '0; m_flag = 1'b0; m_wait = 0;
        RST = 1'b1;
        bus.REQ_VALID = 1'b0; bus.REQ_ADDR = '0; bus.AR_READY = 1'b0;
        bus.R_VALID = 1'b0; bus.R_DATA = '0; bus.R_RESP = 2'b00; bus.RSP_READY = 1'b0;

        // Reset held three cycles, then quiet
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b0);
        idle(2);

        // Basic read
        run_read(64'h8000_0010, 0, 0, 0, 64'hDEAD_BEEF_0123_4567, 2'b00);
        idle(1);
        // Address stall of 5 and response back-pressure of 4
        run_read(64'h1234_5678_9ABC_DEF0, 5, 2, 4, 64'h0F0F_0F0F_A5A5_5A5A, 2'b00);
        // Error responses still return data
        run_read(64'h40, 0, 1, 0, 64'h55, 2'b10);
        run_read(64'h48, 1, 0, 1, 64'h66, 2'b11);
        idle(1);
        // Watchdog: slave ignores AR for a long time, then completes
        run_read(64'hCAFE_0000, 12, 0, 0, 64'h77, 2'b00);
        // Watchdog spanning both address and data waits
        run_read(64'hCAFE_0008, 3, 9, 2, 64'h88, 2'b00);

        // AR_READY and R_VALID together in the address phase: only AR completes
        step(1'b0, 1'b1, 64'hA0, 1'b0, 1'b0, '0, 2'b00, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 64'hBAD, 2'b11, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 64'h99, 2'b00, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 2'b00, 1'b1);

        // Reset in the data phase abandons the read; a new one then works
        step(1'b0, 1'b1, 64'hB000, 1'b0, 1'b0, '0, 2'b00, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 2'b00, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1, 64'h1111, 2'b00, 1'b0);
        idle(2);
        run_read(64'hB100, 0, 0, 0, 64'h2222, 2'b00);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 1) == 1),
                 {$urandom, $urandom},
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 3),
                 {$urandom, $urandom},
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 4));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_read_master.md
Name: axi4_lite_read_master

Overview:
- Initiator end of the AXI4-Lite read channel pair; drives AR and accepts R from an AXI4-Lite read slave.
- Core side is a simple request/response handshake: address in, data plus response code out.
- Handles one outstanding read at a time.
- Sits between the core's load/fetch unit and the memory-side AXI4-Lite read slave.

Parameters:
ADDR_W, 64, width of REQ_ADDR and AR_ADDR
DATA_W, 64, width of R_DATA and RSP_DATA
TIMEOUT, 256, cycles spent in ADDR+DATA before TIMEOUT_FLAG pulses; 0 disables the watchdog

Ports:
CLK  input  1  clock, all logic on posedge
RST  input  1  reset; one clock; reset is synchronous and active-high
REQ_VALID  input  1  core requests a read
REQ_READY  output  1  master can accept a request
REQ_ADDR  input  ADDR_W  read address, sampled on REQ handshake
RSP_VALID  output  1  response available
RSP_READY  input  1  core accepts response
RSP_DATA  output  DATA_W  read data
RSP_ERR  output  2  copy of R_RESP for this transaction
TIMEOUT_FLAG  output  1  one-cycle pulse when watchdog expires
AR_ADDR  output  ADDR_W  AXI read address
AR_VALID  output  1  AXI address valid
AR_READY  input  1  AXI address ready
R_DATA  input  DATA_W  AXI read data
R_RESP  input  2  AXI read response
R_VALID  input  1  AXI data valid
R_READY  output  1  AXI data ready

Behaviour:
- All outputs are registered or decoded from the registered state; no combinational path from any input to any output.
- Reset values: state IDLE, AR_VALID=0, AR_ADDR=0, R_READY=0, RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, TIMEOUT_FLAG=0, watchdog=0. REQ_READY=1 in IDLE.
- Reset asserted mid-transaction: state returns to IDLE at that edge; in-flight AXI beats are abandoned; no response is produced.
- Four-state FSM: IDLE, ADDR, DATA, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID: latch REQ_ADDR into AR_ADDR, set AR_VALID=1, go to ADDR.
- ADDR:
  - AR_VALID=1 and AR_ADDR held stable until the handshake; AR_VALID is never dropped before AR_READY.
  - On AR_VALID&&AR_READY: AR_VALID=0, R_READY=1, go to DATA.
  - R_VALID in this state is ignored.
- DATA:
  - R_READY=1.
  - On R_VALID: latch R_DATA into RSP_DATA and R_RESP into RSP_ERR; R_READY=0, RSP_VALID=1, go to RESP.
- RESP:
  - RSP_VALID=1; RSP_DATA and RSP_ERR held stable.
  - On RSP_READY: RSP_VALID=0, go to IDLE.
- REQ_READY=0 in every state except IDLE.
- Latency, REQ handshake at edge N:
  - AR_VALID high from N+1.
  - With AR_READY high at N+1 and R_VALID high at N+2, RSP_VALID rises at N+3.
  - Minimum 4 cycles from request handshake to next REQ_READY=1 (RESP→IDLE takes one cycle).
- Watchdog:
  - Counts cycles while in ADDR or DATA; cleared on entry to IDLE.
  - When count equals TIMEOUT-1, TIMEOUT_FLAG pulses for exactly one cycle.
  - Counter saturates after that; flag does not repeat.
  - The transaction keeps waiting, so the AXI protocol is never violated.
  - TIMEOUT=0: counter and flag held at 0.
- RSP_ERR passes R_RESP unchanged (00 OKAY, 10 SLVERR, 11 DECERR). Data is returned even on error.
- Simultaneous AR_READY and R_VALID in ADDR: only the address handshake completes; the R beat must be taken in DATA.

Test Plan:
1. Reset held 3 cycles, then released, no request → REQ_READY=1, all AXI valid/ready outputs 0, RSP_VALID=0.
2. REQ_ADDR=0x8000_0010 with REQ_VALID for 1 cycle; slave AR_READY 1 cycle after AR_VALID; R_DATA=0xDEAD_BEEF_0123_4567, R_RESP=00 two cycles later → AR_ADDR=0x8000_0010 stable while AR_VALID; RSP_VALID with RSP_DATA=0xDEAD_BEEF_0123_4567, RSP_ERR=00.
3. AR_READY withheld 5 cycles → AR_VALID and AR_ADDR stable all 5 cycles. RSP_READY held low 4 cycles after RSP_VALID → RSP_DATA stable, REQ_READY=0 throughout.
4. R_RESP=10 with R_DATA=0x55 → RSP_ERR=10, RSP_DATA=0x55.
5. TIMEOUT=8, slave never raises AR_READY → TIMEOUT_FLAG high exactly one cycle, 8 cycles after AR_VALID rose; AR_VALID stays 1. AR_READY later completes the read normally.
6. RST asserted while in DATA → next edge R_READY=0, RSP_VALID=0, REQ_READY=1. A new request then completes with the new address.
